cla_sum: RTL and testbench

CLA_SUM -- requirements
Module: cla_sum

---
 rtl/cla_sum.sv | 117 +++++++++++
 tb/tb_cla_sum.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sum.sv
// Final sum stage behind the 64-bit prefix-carry pipeline: forms sum/carry-out from
// group generate/propagate and buffers results in a FIFO with credit-based in_ready.
module cla_sum #(
   parameter int LAT   = 7,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             cin,
   input  logic [63:0][7:0] y,
   input  logic [63:0]      c,
   input  logic [63:0]      d,
   output logic [63:0]      sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf,
   output logic [15:0]      res_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(LAT + 1) + 1;

   // Carry into bit i from the prefix of bits below it; element 64 is the carry-out.
   function automatic logic [64:0] carry_vec(input logic [63:0][7:0] gp, input logic ci);
      logic [64:0] cv;
      cv[0] = ci;
      for (int i = 1; i <= 64; i++) begin
         cv[i] = gp[i-1][0] | (gp[i-1][1] & ci);
      end
      return cv;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   logic [LAT-1:0] vld_p;
   logic           v_last;
   logic [IW-1:0]  inflight;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW-1:0]  fcnt;
   logic [64:0]    mem [DEPTH];
   logic [64:0]    cv;
   logic [64:0]    res_w;
   logic [64:0]    head;
   logic           full;
   logic           push;
   logic           pop;
   logic           drop;
   logic [5:0]     y_unused;

   always_comb begin
      y_unused = '0;
      for (int i = 0; i < 64; i++) begin
         y_unused = y_unused ^ y[i][7:2];
      end
   end

   // Stage boundary: vld_p[LAT-1] lines up with y/c/d coming out of the prefix pipeline.
   assign v_last = vld_p[LAT-1];

   assign cv    = carry_vec(y, cin);
   assign res_w = {cv[64], c ^ d ^ cv[63:0]};

   assign full      = (fcnt == CW'(DEPTH));
   assign out_valid = (fcnt != '0);
   assign pop       = out_valid & out_ready;
   assign push      = v_last & (~full | pop);
   assign drop      = v_last & full & ~pop;
   assign in_ready  = (32'(inflight) + 32'(fcnt)) < 32'(DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p    <= '0;
         inflight <= '0;
         wptr     <= '0;
         rptr     <= '0;
         fcnt     <= '0;
         ovf      <= 1'b0;
         res_cnt  <= '0;
      end else begin
         vld_p[0] <= in_valid;
         for (int i = 1; i < LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
         case ({in_valid, v_last})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: ;
         endcase
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   fcnt <= fcnt + CW'(1);
            2'b01:   fcnt <= fcnt - CW'(1);
            default: ;
         endcase
         if (drop) ovf <= 1'b1;
         if (pop)  res_cnt <= res_cnt + 16'd1;
      end
   end

   // Storage carries no reset; validity comes entirely from fcnt.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= res_w;
   end

   assign head = mem[rptr];
   assign sum  = out_valid ? head[63:0] : '0;
   assign cout = out_valid ? head[64] : 1'b0;

endmodule

// File: tb/tb_cla_sum.sv
// Bench for cla_sum: models the prefix pipeline and the result FIFO at the arithmetic level.
module tb_cla_sum;

   localparam int LAT   = 7;
   localparam int DEPTH = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             cin;
   logic [63:0][7:0] y;
   logic [63:0]      c;
   logic [63:0]      d;
   logic [63:0]      sum;
   logic             cout;
   logic             out_valid;
   logic             out_ready;
   logic             ovf;
   logic [15:0]      res_cnt;

   logic [63:0] a_in;
   logic [63:0] b_in;
   logic [63:0] pa [LAT];
   logic [63:0] pb [LAT];

   int checks   = 0;
   int failures = 0;

   // Model state: arrival pipeline, result queue, flags.
   bit          mv [LAT];
   logic [63:0] ma [LAT];
   logic [63:0] mb [LAT];
   logic [64:0] mq [$];
   bit          ovf_m;
   logic [15:0] rcnt_m;

   cla_sum #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cin(cin),
      .y(y), .c(c), .d(d), .sum(sum), .cout(cout), .out_valid(out_valid),
      .out_ready(out_ready), .ovf(ovf), .res_cnt(res_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0][7:0] ppc_out(input logic [63:0] a, input logic [63:0] b);
      logic [63:0][7:0] r;
      logic [64:0]      s;
      logic [63:0]      m;
      for (int i = 0; i < 64; i++) begin
         m = (i == 63) ? '1 : ((64'd1 << (i + 1)) - 64'd1);
         s = {1'b0, a & m} + {1'b0, b & m};
         r[i][0]   = s[i+1];
         r[i][1]   = &((a ^ b) | ~m);
         r[i][7:2] = 6'(i);
      end
      return r;
   endfunction

   // Stand-in for the external prefix pipeline; its data registers are never reset.
   always @(posedge clk) begin
      pa[0] <= a_in;
      pb[0] <= b_in;
      for (int i = 1; i < LAT; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end

   always_comb begin
      y = ppc_out(pa[LAT-1], pb[LAT-1]);
      c = pa[LAT-1];
      d = pb[LAT-1];
   end

   function automatic logic [64:0] add_ref(input logic [63:0] a, input logic [63:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + 65'(ci);
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_all();
      int busy;
      busy = 0;
      for (int i = 0; i < LAT; i++) busy += int'(mv[i]);
      chk("in_ready", 65'(in_ready), 65'((busy + mq.size()) < DEPTH));
      chk("out_valid", 65'(out_valid), 65'(mq.size() != 0));
      chk("ovf", 65'(ovf), 65'(ovf_m));
      chk("res_cnt", 65'(res_cnt), 65'(rcnt_m));
      if (mq.size() != 0) chk("head", {cout, sum}, mq[0]);
   endtask

   task automatic tick();
      if (mq.size() != 0 && out_ready) begin
         void'(mq.pop_front());
         rcnt_m = rcnt_m + 16'd1;
      end
      if (mv[LAT-1]) begin
         if (mq.size() < DEPTH) mq.push_back(add_ref(ma[LAT-1], mb[LAT-1], cin));
         else ovf_m = 1'b1;
      end
      for (int i = LAT - 1; i > 0; i--) begin
         mv[i] = mv[i-1];
         ma[i] = ma[i-1];
         mb[i] = mb[i-1];
      end
      mv[0] = in_valid;
      ma[0] = a_in;
      mb[0] = b_in;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic model_clear();
      mq.delete();
      for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
      ovf_m  = 1'b0;
      rcnt_m = '0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 65'(out_valid), 65'd0);
      chk("rst_in_ready", 65'(in_ready), 65'd1);
      chk("rst_sum", 65'(sum), 65'd0);
      chk("rst_cout", 65'(cout), 65'd0);
      chk("rst_ovf", 65'(ovf), 65'd0);
      chk("rst_res_cnt", 65'(res_cnt), 65'd0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_ops();
      a_in = {$urandom(), $urandom()};
      b_in = {$urandom(), $urandom()};
   endtask

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        ci;
      logic [63:0] s;
      logic        co;
   } vec_t;

   vec_t        tbl [6];
   logic [64:0] eq [$];
   logic [64:0] first_exp;
   int          n;
   int          acc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
      model_clear();
      #2 rst = 1'b0;
      #2;
      chk("init_out_valid", 65'(out_valid), 65'd0);
      chk("init_in_ready", 65'(in_ready), 65'd1);
      chk("init_sum", {cout, sum}, 65'd0);
      chk("init_ovf", 65'(ovf), 65'd0);
      chk("init_res_cnt", 65'(res_cnt), 65'd0);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      check_all();

      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
      tbl[1] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'd0, 1'b1};
      tbl[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[3] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
      tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};

      for (int k = 0; k < 6; k++) begin
         cin = tbl[k].ci; a_in = tbl[k].a; b_in = tbl[k].b;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 20) begin
            tick();
            n++;
         end
         chk($sformatf("vec%0d_latency", k), 65'(n), 65'd8);
         chk($sformatf("vec%0d_sum", k), 65'(sum), 65'(tbl[k].s));
         chk($sformatf("vec%0d_cout", k), 65'(cout), 65'(tbl[k].co));
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end

      // Random traffic against the queue model, one fixed carry-in per segment.
      for (int seg = 0; seg < 2; seg++) begin
         cin = seg[0];
         for (int t = 0; t < 300; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = in_ready ? $urandom_range(0, 1) == 1 : $urandom_range(0, 15) == 0;
            rand_ops();
            tick();
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         repeat (LAT + DEPTH + 2) tick();
         out_ready = 1'b0;
      end

      // Fill while stalled, then overflow, then drain in order.
      do_reset();
      cin = 1'b0; acc = 0; eq.delete();
      for (int t = 0; t < 20; t++) begin
         in_valid = in_ready;
         rand_ops();
         if (in_valid) begin
            acc++;
            eq.push_back(add_ref(a_in, b_in, cin));
         end
         tick();
      end
      in_valid = 1'b0;
      chk("fill_accepts", 65'(acc), 65'd8);
      chk("fill_out_valid", 65'(out_valid), 65'd1);
      chk("fill_in_ready", 65'(in_ready), 65'd0);
      first_exp = eq[0];
      in_valid = 1'b1;
      rand_ops();
      tick();
      in_valid = 1'b0;
      repeat (LAT - 1) tick();
      chk("ovf_before_arrival", 65'(ovf), 65'd0);
      tick();
      chk("ovf_on_arrival", 65'(ovf), 65'd1);
      chk("ovf_head_kept", {cout, sum}, first_exp);
      repeat (5) tick();
      chk("ovf_sticky", 65'(ovf), 65'd1);
      out_ready = 1'b1;
      n = 0;
      while (out_valid && n < 20) begin
         chk("drain_order", {cout, sum}, (eq.size() != 0) ? eq.pop_front() : 65'd0);
         tick();
         n++;
      end
      out_ready = 1'b0;
      chk("drain_pops", 65'(n), 65'd8);
      chk("drain_res_cnt", 65'(res_cnt), 65'd8);
      chk("drain_ovf_sticky", 65'(ovf), 65'd1);

      // Full FIFO with push and pop together every cycle across pointer wrap.
      do_reset();
      cin = 1'b1; eq.delete();
      for (int t = 0; t < 20; t++) begin
         in_valid = in_ready;
         rand_ops();
         if (in_valid) eq.push_back(add_ref(a_in, b_in, cin));
         tick();
      end
      for (int t = 0; t < LAT + 20; t++) begin
         in_valid  = (t < 20);
         out_ready = (t >= LAT);
         rand_ops();
         if (in_valid) eq.push_back(add_ref(a_in, b_in, cin));
         if (out_ready) chk("stream_order", {cout, sum}, (eq.size() != 0) ? eq.pop_front() : 65'd0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("stream_no_ovf", 65'(ovf), 65'd0);
      chk("stream_full", 65'(in_ready), 65'd0);
      out_ready = 1'b1;
      n = 0;
      while (out_valid && n < 20) begin
         chk("stream_drain_order", {cout, sum}, (eq.size() != 0) ? eq.pop_front() : 65'd0);
         tick();
         n++;
      end
      out_ready = 1'b0;
      chk("stream_drain_pops", 65'(n), 65'd8);

      // Reset with results buffered and two operations in flight.
      do_reset();
      cin = 1'b0;
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1;
         rand_ops();
         tick();
      end
      in_valid = 1'b0;
      repeat (LAT + 1) tick();
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1;
         rand_ops();
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("pre_rst_out_valid", 65'(out_valid), 65'd1);
      do_reset();
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         chk("post_rst_no_valid", 65'(out_valid), 65'd0);
      end
      out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
